// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   ldr_state_e      : loader FSM encodings
//   WORD_BYTES       : bytes per memory word (also the byte count of the length header)
//   accepts_bytes()  : true in the states that take bytes from the receiver
package imem_loader_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        LDR_LEN  = 3'd0,
        LDR_DATA = 3'd1,
        LDR_CSUM = 3'd2,
        LDR_DONE = 3'd3,
        LDR_ERR  = 3'd4
    } ldr_state_e;

    function automatic logic accepts_bytes(input ldr_state_e s);
        return (s == LDR_LEN) || (s == LDR_DATA) || (s == LDR_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Assembles a little-endian 32-bit word from a byte stream.
// The first byte of each group of four lands in word[7:0].
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous re-align to byte lane 0
//   byte_valid  : byte_data is consumed this cycle
//   byte_data   : incoming byte
//   word        : assembled word, valid only while word_valid is high
//   word_valid  : high in the cycle the fourth byte of a word is consumed
module imem_loader_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam int LANE_W = $clog2(WORD_BYTES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);

    logic [LANE_W-1:0] lane_q;
    logic [23:0]       shift_q;

    // Bytes enter at the top and move down, so after three bytes shift_q
    // holds {b2, b1, b0}; the fourth byte completes the word combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q  <= '0;
            shift_q <= '0;
        end else if (clear) begin
            lane_q  <= '0;
            shift_q <= '0;
        end else if (byte_valid) begin
            lane_q  <= lane_q + LANE_W'(1);
            shift_q <= {byte_data, shift_q[23:8]};
        end
    end

    assign word       = {byte_data, shift_q};
    assign word_valid = byte_valid && (lane_q == LAST_LANE);

endmodule

// File: rtl/imem_loader.sv
// Boot-image loader: writes a byte-streamed image into instruction memory
// and holds the core in reset until a complete, checksum-valid image is in.
// Frame: 4-byte LE word count N, N LE payload words, 1 byte checksum
// (payload byte sum mod 256).
//
// state     | meaning
// ----------+-----------------------------------------------
// LDR_LEN   | collecting the 4 length bytes
// LDR_DATA  | collecting payload, one memory write per word
// LDR_CSUM  | waiting for the checksum byte
// LDR_DONE  | image valid, core released, input closed
// LDR_ERR   | oversize length or bad checksum, input closed
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   rx_valid/rx_data    : byte stream in; transfer when rx_valid && rx_ready
//   rx_ready            : loader is accepting bytes
//   restart             : one-cycle pulse, abandon and re-arm for a new frame
//   wr_en/wr_addr/wr_data : synchronous memory write port, one strobe per word
//   busy                : frame in progress
//   done / error        : terminal status levels
//   cpu_rst_n           : core reset, released together with done
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        restart,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_rst_n
);

    localparam int IDX_W = $clog2(MAX_WORDS) + 1;
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    ldr_state_e state_q, state_nxt;

    logic             accept;
    logic             pk_in;
    logic             pk_valid;
    logic [31:0]      pk_word;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] n_words_q;
    logic [7:0]       sum_q;
    logic             busy_q;
    logic             len_too_big;
    logic             last_word;

    // restart wins over a byte presented in the same cycle
    assign accept      = rx_valid && rx_ready && !restart;
    assign pk_in       = accept && ((state_q == LDR_LEN) || (state_q == LDR_DATA));
    assign len_too_big = pk_word > 32'(MAX_WORDS);
    assign last_word   = (idx_q + IDX_ONE) == n_words_q;

    // Length header and payload share one packer: the lane counter wraps
    // after each four bytes, so it is already aligned when DATA begins.
    imem_loader_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (restart),
        .byte_valid (pk_in),
        .byte_data  (rx_data),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LDR_LEN;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        rx_ready  = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cpu_rst_n = 1'b0;

        unique case (state_q)
            LDR_LEN: begin
                rx_ready = 1'b1;
                if (pk_valid) begin
                    if (len_too_big)
                        state_nxt = LDR_ERR;
                    else if (pk_word == 32'd0)
                        state_nxt = LDR_CSUM;
                    else
                        state_nxt = LDR_DATA;
                end
            end
            LDR_DATA: begin
                rx_ready = 1'b1;
                if (pk_valid && last_word)
                    state_nxt = LDR_CSUM;
            end
            LDR_CSUM: begin
                rx_ready = 1'b1;
                if (accept)
                    state_nxt = (rx_data == sum_q) ? LDR_DONE : LDR_ERR;
            end
            LDR_DONE: begin
                done      = 1'b1;
                cpu_rst_n = 1'b1;
            end
            LDR_ERR: begin
                error = 1'b1;
            end
            default: state_nxt = LDR_LEN;
        endcase

        if (restart)
            state_nxt = LDR_LEN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            n_words_q <= '0;
            sum_q     <= '0;
            busy_q    <= 1'b0;
        end else if (restart) begin
            idx_q     <= '0;
            n_words_q <= '0;
            sum_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            if (state_q == LDR_LEN && pk_valid)
                n_words_q <= pk_word[IDX_W-1:0];
            if (state_q == LDR_DATA && accept)
                sum_q <= sum_q + rx_data;
            if (state_q == LDR_DATA && pk_valid)
                idx_q <= idx_q + IDX_ONE;

            if (state_nxt == LDR_DONE || state_nxt == LDR_ERR)
                busy_q <= 1'b0;
            else if (accept)
                busy_q <= 1'b1;
        end
    end

    // Write port is registered: a completed word appears one cycle after
    // its fourth byte. A strobe already registered when restart arrives
    // still issues, because restart only gates the packer input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= BASE_ADDR;
            wr_data <= '0;
        end else begin
            wr_en <= (state_q == LDR_DATA) && pk_valid;
            if ((state_q == LDR_DATA) && pk_valid) begin
                wr_addr <= BASE_ADDR + {{(30-IDX_W){1'b0}}, idx_q, 2'b00};
                wr_data <= pk_word;
            end
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        restart;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_rst_n;

    imem_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .restart   (restart),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cpu_rst_n (cpu_rst_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t  exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic [7:0] tb_sum;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write,
    // including the cycle it was due in.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_en === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL wr_unexpected observed addr=%h data=%h expected no write", wr_addr, wr_data);
            end
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", wr_addr, e.addr);
                chk("wr_data", wr_data, e.data);
                chk("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called just after a falling edge; returns just after the next one.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_len(input logic [31:0] n);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
    endtask

    task automatic send_word(input logic [31:0] addr, input logic [31:0] data, input int gap_max);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            if (i == 3) exp_q.push_back('{addr: addr, data: data, cyc: cyc + 1});
            tb_sum = tb_sum + data[8*i +: 8];
            send_byte(data[8*i +: 8]);
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic e_done, input logic e_err, input logic e_rdy, input logic e_busy);
        chk({tag, "_done"}, 32'(done), 32'(e_done));
        chk({tag, "_error"}, 32'(error), 32'(e_err));
        chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(e_done));
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'(e_rdy));
        chk({tag, "_busy"}, 32'(busy), 32'(e_busy));
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        restart  = 1'b0;
        tb_sum   = 8'h00;
        repeat (3) @(negedge clk);

        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", wr_addr, 32'h0);
        chk("rst_wr_data", wr_data, 32'h0);
        chk_status("rst", 1'b0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Good two-word frame
        send_byte(8'h02);
        chk("t1_busy_after_first", 32'(busy), 32'd1);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        tb_sum = 8'h00;
        send_word(32'h0, 32'h1234_5678, 0);
        send_word(32'h4, 32'hDEAD_BEEF, 0);
        chk("t1_sum_model", 32'(tb_sum), 32'h4C);
        send_byte(tb_sum);
        chk_status("t1", 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("t1_done_holds", 32'(done), 32'd1);
        pulse_restart();
        chk_status("t1_restart", 1'b0, 1'b0, 1'b1, 1'b0);

        // Same frame, bad checksum
        send_len(32'd2);
        tb_sum = 8'h00;
        send_word(32'h0, 32'h1234_5678, 0);
        send_word(32'h4, 32'hDEAD_BEEF, 0);
        send_byte(tb_sum + 8'h01);
        chk_status("t2", 1'b0, 1'b1, 1'b0, 1'b0);
        pulse_restart();

        // Empty image
        send_len(32'd0);
        send_byte(8'h00);
        chk_status("t3", 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_restart();

        // Oversize length: error right after the fourth header byte
        send_len(32'd16385);
        chk_status("t4", 1'b0, 1'b1, 1'b0, 1'b0);
        pulse_restart();

        // Gapped stream, checksum wraps past 255
        send_len(32'd3);
        tb_sum = 8'h00;
        send_word(32'h0, 32'hFFEE_DDCC, 3);
        send_word(32'h4, 32'h8080_8080, 3);
        send_word(32'h8, 32'h0BAD_F00D, 3);
        repeat (2) @(negedge clk);
        send_byte(tb_sum);
        chk_status("t5", 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_restart();

        // Restart after 6 payload bytes, with a byte coincident with restart
        send_len(32'd2);
        tb_sum = 8'h00;
        send_word(32'h0, 32'h4433_2211, 0);
        send_byte(8'h55);
        send_byte(8'h66);
        restart  = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        @(negedge clk);
        restart  = 1'b0;
        rx_valid = 1'b0;
        chk_status("t6_restart", 1'b0, 1'b0, 1'b1, 1'b0);
        send_len(32'd1);
        tb_sum = 8'h00;
        send_word(32'h0, 32'h0000_0001, 0);
        send_byte(tb_sum);
        chk_status("t6", 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_restart();

        // Asynchronous reset mid-DATA, then a fresh frame
        send_len(32'd2);
        tb_sum = 8'h00;
        send_word(32'h0, 32'hCAFE_F00D, 0);
        send_byte(8'h11);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_wr_en", 32'(wr_en), 32'd0);
        chk("t7_wr_addr", wr_addr, 32'h0);
        chk("t7_wr_data", wr_data, 32'h0);
        chk_status("t7_rst", 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_len(32'd1);
        tb_sum = 8'h00;
        send_word(32'h0, 32'hA5A5_5A5A, 0);
        send_byte(tb_sum);
        chk_status("t7", 1'b1, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
